gmii_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one GMII/RGMII transmit datapath between `NUM_REQ` frame sources, such as UDP packet senders and ARP/ICMP responders. It grants the link to one requester at a time and forwards that requester's `tx_d`/`tx_dv` stream for exactly one frame. It enforces the Ethernet inter-frame gap and watchdogs stuck or over-long requesters. It sits between the packet builders and the RGMII TX PHY adapter, in the same clock domain as the transmit byte stream.

---
 rtl/rgmii_pkg.sv | 28 ++
 rtl/gmii_tx_arbiter_rr.sv | 30 +++
 rtl/gmii_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_gmii_tx_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgmii_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rgmii_pkg: shared RGMII/GMII framing constants and TX arbiter state type.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package rgmii_pkg;

    localparam int PREAMBLE_BYTES      = 7;
    localparam int SFD_BYTES           = 1;
    localparam int FCS_BYTES           = 4;
    localparam int IFG_BYTES_DEF       = 12;
    localparam int MAX_FRAME_BYTES_DEF = 1526;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        ACTIVE = 2'd2,
        IFG    = 2'd3
    } tx_arb_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gmii_tx_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter: combinational round-robin pick, first request at/after ptr_i.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] pick_o,
    output logic               valid_o
);

    logic [NUM_REQ-1:0] w_mask;
    logic [NUM_REQ-1:0] w_hi;
    logic [NUM_REQ-1:0] w_sel;

    // Prefer requests at or above the pointer; wrap to the full vector otherwise.
    always_comb begin
        w_mask  = ~((NUM_REQ'(1) << ptr_i) - NUM_REQ'(1));
        w_hi    = req_i & w_mask;
        w_sel   = (|w_hi) ? w_hi : req_i;
        pick_o  = w_sel & (~w_sel + NUM_REQ'(1));
        valid_o = |req_i;
    end

endmodule
`default_nettype wire

// File: rtl/gmii_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gmii_tx_arbiter: round-robin sharing of one GMII TX stream, IFG + watchdogs.|
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module gmii_tx_arbiter
    import rgmii_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int GMII_WIDTH      = 8,
    parameter int IFG_BYTES       = IFG_BYTES_DEF,
    parameter int MAX_FRAME_BYTES = MAX_FRAME_BYTES_DEF,
    parameter int START_TIMEOUT   = 64
) (
    input  logic                                clk_i,
    input  logic                                rstn_i,
    input  logic [NUM_REQ-1:0]                  req_i,
    output logic [NUM_REQ-1:0]                  gnt_o,
    input  logic [NUM_REQ-1:0][GMII_WIDTH-1:0]  tx_d_i,
    input  logic [NUM_REQ-1:0]                  tx_dv_i,
    output logic [GMII_WIDTH-1:0]               tx_d_o,
    output logic                                tx_dv_o,
    output logic                                busy_o,
    output logic                                err_o,
    output logic [31:0]                         frame_cnt_o
);

    localparam int IFG_LEN = IFG_BYTES * 8 / GMII_WIDTH;
    localparam int MAX_LEN = MAX_FRAME_BYTES * 8 / GMII_WIDTH;
    localparam int TW      = $clog2(max3(MAX_LEN, START_TIMEOUT, IFG_LEN) + 1);
    localparam int IW      = $clog2(NUM_REQ);

    localparam logic [TW-1:0] C_TO_LAST  = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] C_LEN_LAST = TW'(MAX_LEN - 1);
    // The IDLE and GRANT cycles also show tx_dv_o low, so the IFG state itself
    // is two cycles shorter to keep the wire gap at exactly IFG_LEN.
    localparam logic [TW-1:0] C_IFG_LAST = TW'(IFG_LEN - 3);

    tx_arb_state_t           state_q;
    logic [NUM_REQ-1:0]      gnt_q;
    logic [IW-1:0]           idx_q;
    logic [IW-1:0]           ptr_q;
    logic [TW-1:0]           timer_q;
    logic [GMII_WIDTH-1:0]   tx_d_q;
    logic                    tx_dv_q;
    logic                    err_q;
    logic [31:0]             frame_cnt_q;

    logic [NUM_REQ-1:0]      w_pick;
    logic                    w_valid;
    logic [IW-1:0]           w_idx;
    logic [IW-1:0]           ptr_d;
    logic                    w_dv;
    logic                    w_req;
    logic [GMII_WIDTH-1:0]   w_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (IW)
    ) u_rr (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .pick_o  (w_pick),
        .valid_o (w_valid)
    );

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick[i]) w_idx = IW'(i);
        end
        ptr_d = (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + IW'(1);
    end

    assign w_dv  = tx_dv_i[idx_q];
    assign w_req = req_i[idx_q];
    assign w_d   = tx_d_i[idx_q];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            idx_q       <= '0;
            ptr_q       <= '0;
            timer_q     <= '0;
            tx_d_q      <= '0;
            tx_dv_q     <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            err_q   <= 1'b0;
            timer_q <= timer_q + TW'(1);
            case (state_q)
                IDLE: begin
                    tx_dv_q <= 1'b0;
                    tx_d_q  <= '0;
                    timer_q <= '0;
                    if (w_valid) begin
                        gnt_q   <= w_pick;
                        idx_q   <= w_idx;
                        ptr_q   <= ptr_d;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_dv) begin
                        tx_dv_q <= 1'b1;
                        tx_d_q  <= w_d;
                        timer_q <= '0;
                        state_q <= ACTIVE;
                    end else if (!w_req) begin
                        gnt_q   <= '0;
                        timer_q <= '0;
                        state_q <= IDLE;
                    end else if (timer_q == C_TO_LAST) begin
                        err_q   <= 1'b1;
                        gnt_q   <= '0;
                        timer_q <= '0;
                        state_q <= IDLE;
                    end
                end
                ACTIVE: begin
                    // timer_q + 1 beats have been forwarded on entry to this cycle.
                    if (!w_dv) begin
                        tx_dv_q     <= 1'b0;
                        tx_d_q      <= '0;
                        gnt_q       <= '0;
                        frame_cnt_q <= frame_cnt_q + 32'd1;
                        timer_q     <= '0;
                        state_q     <= IFG;
                    end else if (timer_q == C_LEN_LAST) begin
                        tx_dv_q <= 1'b0;
                        tx_d_q  <= '0;
                        gnt_q   <= '0;
                        err_q   <= 1'b1;
                        timer_q <= '0;
                        state_q <= IFG;
                    end else begin
                        tx_dv_q <= 1'b1;
                        tx_d_q  <= w_d;
                    end
                end
                IFG: begin
                    tx_dv_q <= 1'b0;
                    tx_d_q  <= '0;
                    if (timer_q == C_IFG_LAST) begin
                        timer_q <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign tx_d_o      = tx_d_q;
    assign tx_dv_o     = tx_dv_q;
    assign busy_o      = (state_q != IDLE);
    assign err_o       = err_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gmii_tx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_gmii_tx_arbiter: directed, table-driven bench for gmii_tx_arbiter.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_gmii_tx_arbiter;

    logic            clk = 1'b0;
    logic            rstn;
    logic [3:0]      tb_req;
    logic [3:0]      tb_dv;
    logic [3:0][7:0] tb_d;
    logic [3:0]      gnt;
    logic [7:0]      txd;
    logic            txdv;
    logic            busy;
    logic            err;
    logic [31:0]     fcnt;

    logic [3:0]      ol_req;
    logic [3:0]      ol_dv;
    logic [3:0][7:0] ol_d;
    logic [3:0]      ol_gnt;
    logic [7:0]      ol_txd;
    logic            ol_txdv;
    logic            ol_busy;
    logic            ol_err;
    logic [31:0]     ol_fcnt;

    int checks = 0;
    int errors = 0;

    int gaps[$];
    int low_run   = 0;
    bit seen_high = 1'b0;
    int errs      = 0;
    int leaks     = 0;

    always #5 clk = ~clk;

    gmii_tx_arbiter u_dut (
        .clk_i(clk), .rstn_i(rstn), .req_i(tb_req), .gnt_o(gnt),
        .tx_d_i(tb_d), .tx_dv_i(tb_dv), .tx_d_o(txd), .tx_dv_o(txdv),
        .busy_o(busy), .err_o(err), .frame_cnt_o(fcnt)
    );

    gmii_tx_arbiter #(.MAX_FRAME_BYTES(100)) u_dut_ol (
        .clk_i(clk), .rstn_i(rstn), .req_i(ol_req), .gnt_o(ol_gnt),
        .tx_d_i(ol_d), .tx_dv_i(ol_dv), .tx_d_o(ol_txd), .tx_dv_o(ol_txdv),
        .busy_o(ol_busy), .err_o(ol_err), .frame_cnt_o(ol_fcnt)
    );

    // Output-side monitor: inter-frame low-cycle runs, error pulses, leaked beats.
    always @(negedge clk) begin
        if (!rstn) begin
            seen_high <= 1'b0;
            low_run   <= 0;
        end else if (txdv) begin
            if (seen_high && low_run > 0) gaps.push_back(low_run);
            seen_high <= 1'b1;
            low_run   <= 0;
            if (txd == 8'hEE) leaks <= leaks + 1;
        end else begin
            low_run <= low_run + 1;
        end
        if (err) errs <= errs + 1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat(input int src, input int b);
        return {1'b0, 2'(src), 5'(b)};
    endfunction

    task automatic drive_frame(input int src, input int n, input bit tog, output int bad);
        bad = 0;
        for (int b = 0; b < n; b++) begin
            tb_dv = '0;
            tb_d  = '0;
            if (tog) begin
                for (int j = 0; j < 4; j++) begin
                    if (j != src) begin
                        tb_dv[j] = b[0];
                        tb_d[j]  = 8'hEE;
                    end
                end
            end
            tb_dv[src] = 1'b1;
            tb_d[src]  = pat(src, b);
            tick;
            if (txdv !== 1'b1 || txd !== pat(src, b)) bad++;
        end
        tb_dv = '0;
        tb_d  = '0;
    endtask

    task automatic wait_any_gnt(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick;
            if (gnt != 4'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int bad, totbad, vcnt, errc, gbad, idx;
        bit ok;
        int order[5];
        int exp_order[5];

        // Pointer walks from 0; each grant is abandoned in GRANT (no data, no IFG).
        vecs[0] = '{4'b0001, 4'b0001};
        vecs[1] = '{4'b0001, 4'b0001};
        vecs[2] = '{4'b1111, 4'b0010};
        vecs[3] = '{4'b1111, 4'b0100};
        vecs[4] = '{4'b0011, 4'b0001};
        vecs[5] = '{4'b1100, 4'b0100};
        vecs[6] = '{4'b1001, 4'b1000};
        vecs[7] = '{4'b0110, 4'b0010};
        vecs[8] = '{4'b0000, 4'b0000};
        vecs[9] = '{4'b1011, 4'b1000};
        exp_order = '{0, 1, 2, 3, 0};

        rstn = 1'b0;
        tb_req = '0; tb_dv = '0; tb_d = '0;
        ol_req = '0; ol_dv = '0; ol_d = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst gnt", gnt, 0);
        check("rst txdv", txdv, 0);
        check("rst txd", txd, 0);
        check("rst busy", busy, 0);
        check("rst err", err, 0);
        check("rst fcnt", fcnt, 0);
        @(negedge clk) rstn = 1'b1;
        tick;

        for (int i = 0; i < 10; i++) begin
            tb_req = vecs[i].req;
            tick;
            check($sformatf("vec%0d gnt", i), gnt, vecs[i].gnt);
            check($sformatf("vec%0d busy", i), busy, 32'(vecs[i].gnt != 4'b0));
            tb_req = '0;
            tick;
            check($sformatf("vec%0d release", i), gnt, 0);
        end

        // Single persistent source: 72-beat frame, then a 10-beat frame after the IFG.
        tb_req = 4'b0100;
        tick;
        check("single gnt latency", gnt, 4'b0100);
        drive_frame(2, 72, 1'b0, bad);
        check("single beats", bad, 0);
        tick;
        check("single end gnt", gnt, 0);
        check("single end txdv", txdv, 0);
        check("single fcnt1", fcnt, 1);
        wait_any_gnt(ok);
        check("single regrant", gnt, 4'b0100);
        tb_req = '0;
        drive_frame(2, 10, 1'b0, bad);
        check("single beats2", bad, 0);
        tick;
        check("single fcnt2", fcnt, 2);
        check("single gap", (gaps.size() > 0) ? gaps[$] : -1, 12);
        check("single no err", errs, 0);

        // Start timeout on source 1 while source 3 waits.
        for (int c = 0; c < 100 && busy; c++) tick;
        check("idle before timeout", busy, 0);
        tb_req = 4'b0010;
        tick;
        check("to gnt", gnt, 4'b0010);
        tb_req = 4'b1010;
        bad = 0;
        for (int c = 0; c < 63; c++) begin
            tick;
            if (err !== 1'b0 || gnt !== 4'b0010) bad++;
        end
        check("to wait", bad, 0);
        tick;
        check("to err", err, 1);
        check("to gnt drop", gnt, 0);
        check("to no ifg", busy, 0);
        tick;
        check("to next gnt", gnt, 4'b1000);
        check("to err pulse", err, 0);
        tb_req = '0;
        tick;
        check("to err count", errs, 1);

        // Over-length on the 100-byte instance: 150 beats offered.
        ol_req = 4'b0001;
        tick;
        check("ol gnt", ol_gnt, 4'b0001);
        ol_req = '0;
        vcnt = 0; bad = 0; errc = 0;
        for (int b = 0; b < 180; b++) begin
            ol_dv    = (b < 150) ? 4'b0001 : 4'b0000;
            ol_d[0]  = (b < 150) ? 8'(b) : 8'h00;
            tick;
            if (ol_txdv) begin
                vcnt++;
                if (ol_txd !== 8'(vcnt - 1)) bad++;
            end
            if (ol_err) errc++;
        end
        ol_dv = '0;
        ol_d  = '0;
        check("ol valid beats", vcnt, 100);
        check("ol data", bad, 0);
        check("ol err pulses", errc, 1);
        check("ol fcnt", ol_fcnt, 0);
        check("ol gnt end", ol_gnt, 0);

        // Reset in the middle of a frame from source 1, others toggling.
        tb_req = 4'b0010;
        tick;
        check("rm gnt", gnt, 4'b0010);
        tb_req = '0;
        drive_frame(1, 20, 1'b1, bad);
        check("rm beats", bad, 0);
        tb_dv    = 4'b1111;
        tb_d     = {8'hEE, 8'hEE, pat(1, 20), 8'hEE};
        #2;
        rstn = 1'b0;
        #1;
        check("rm txdv async", txdv, 0);
        check("rm gnt async", gnt, 0);
        check("rm busy async", busy, 0);
        check("rm fcnt", fcnt, 0);
        tb_dv = '0;
        tb_d  = '0;
        @(negedge clk) rstn = 1'b1;
        tick;
        tb_req = 4'b1111;
        tick;
        check("rm first gnt", gnt, 4'b0001);

        // Fairness: all four request continuously, 10-beat frames.
        totbad = 0;
        for (int k = 0; k < 5; k++) begin
            ok = 1'b1;
            if (k > 0) wait_any_gnt(ok);
            idx = -1;
            for (int j = 0; j < 4; j++) if (gnt[j]) idx = j;
            order[k] = idx;
            if (!ok || idx < 0) begin
                check("fair grant timeout", 0, 1);
                break;
            end
            if (k == 4) tb_req = '0;
            drive_frame(idx, 10, 1'b1, bad);
            totbad += bad;
            tick;
        end
        for (int k = 0; k < 5; k++) check($sformatf("fair order%0d", k), order[k], exp_order[k]);
        check("fair beats", totbad, 0);
        check("fair fcnt", fcnt, 5);
        gbad = 0;
        if (gaps.size() < 4) gbad = 99;
        else for (int g = gaps.size() - 4; g < gaps.size(); g++) if (gaps[g] != 12) gbad++;
        check("fair gaps", gbad, 0);
        check("isolation leaks", leaks, 0);
        check("no stray err", errs, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
